// File: rtl/md_defs.sv
// rtl/md_defs.sv - shared encodings for the multiply/divide unit
//
// Purpose: operation and state encodings used by md_unit and its bench.
// Ports:   none (package).

package md_defs;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/md_abs_neg.sv
// rtl/md_abs_neg.sv - conditional two's-complement negate
//
// Purpose: y = neg ? -a : a. Turns signed operands into magnitudes and
//          re-applies the result sign after an unsigned iteration.
// Ports:   a   - input value
//          neg - negate when 1
//          y   - result

module md_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO
//
// Purpose: radix-2 multiply/divide with a fixed 33-cycle latency, plus the
//          architectural HI/LO registers and their MTHI/MTLO write path.
// Ports:   clk, rst        - clock, asynchronous active-high reset
//          start, op       - issue request and operation (sampled when idle)
//          arg1, arg2      - rs / rt operands, captured at the start edge
//          hi_we, lo_we    - MTHI / MTLO enables (idle only), data on wdata
//          busy            - operation in progress
//          done            - one-cycle pulse when HI/LO hold a new result
//          hi, lo          - HI / LO registers

module md_unit
    import md_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] arg1,
    input  logic [WIDTH-1:0] arg2,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    // Shared accumulator. Multiply: [2W:W] running sum, [W-1:0] multiplier
    // shifting out. Divide: [2W-1:W] partial remainder, [W-1:0] dividend
    // shifting out while quotient bits shift in.
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;       // multiplicand or divisor magnitude
    logic               is_div_q, is_div_d;
    logic               neg_a_q, neg_a_d;   // operand sign flags (0 for unsigned ops)
    logic               neg_b_q, neg_b_d;
    logic               dz_q, dz_d;         // divisor was zero
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               is_signed;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH:0]     mul_add, mul_sum;
    logic [2*WIDTH:0]   mul_next;
    logic [2*WIDTH:0]   div_shift, div_next;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign is_signed = (op == MD_MULT) || (op == MD_DIV);

    md_abs_neg #(.WIDTH(WIDTH)) u_abs1 (
        .a(arg1), .neg(is_signed & arg1[WIDTH-1]), .y(abs1)
    );
    md_abs_neg #(.WIDTH(WIDTH)) u_abs2 (
        .a(arg2), .neg(is_signed & arg2[WIDTH-1]), .y(abs2)
    );

    // Result sign correction, applied in FIX.
    md_abs_neg #(.WIDTH(2*WIDTH)) u_prod_fix (
        .a(acc_q[2*WIDTH-1:0]), .neg(neg_a_q ^ neg_b_q), .y(prod_fix)
    );
    md_abs_neg #(.WIDTH(WIDTH)) u_quot_fix (
        .a(acc_q[WIDTH-1:0]), .neg(neg_a_q ^ neg_b_q), .y(quot_fix)
    );
    md_abs_neg #(.WIDTH(WIDTH)) u_rem_fix (
        .a(acc_q[2*WIDTH-1:WIDTH]), .neg(neg_a_q), .y(rem_fix)
    );

    // Shift-add step: add the multiplicand when the outgoing multiplier bit
    // is set, then shift the whole accumulator right by one.
    always_comb begin
        mul_add  = acc_q[0] ? {1'b0, opb_q} : '0;
        mul_sum  = acc_q[2*WIDTH:WIDTH] + mul_add;
        mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
    end

    // Restoring shift-subtract step. A borrow (diff MSB set) keeps the
    // shifted remainder and records a 0 quotient bit. With a zero divisor
    // every trial succeeds, so the remainder ends as the dividend magnitude.
    always_comb begin
        div_shift = {acc_q[2*WIDTH-1:0], 1'b0};
        div_diff  = div_shift[2*WIDTH:WIDTH] - {1'b0, opb_q};
        div_next  = div_diff[WIDTH] ? div_shift
                                    : {div_diff, div_shift[WIDTH-1:1], 1'b1};
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // start wins over a same-cycle MTHI/MTLO write
                    is_div_d = op[1];
                    neg_a_d  = is_signed & arg1[WIDTH-1];
                    neg_b_d  = is_signed & arg2[WIDTH-1];
                    dz_d     = (arg2 == '0);
                    opb_d    = op[1] ? abs2 : abs1;
                    acc_d    = {{(WIDTH+1){1'b0}}, (op[1] ? abs1 : abs2)};
                    count_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = S_CALC;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_CALC: begin
                acc_d   = is_div_q ? div_next : mul_next;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_STEP) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    // remainder path already yields arg1 itself on divide-by-zero
                    hi_d = rem_fix;
                    lo_d = dz_q ? '1 : quot_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
